// File: rtl/bbox_sample_iter_if.sv
// Triangle-in / sample-group-out handshake bundle for bbox_sample_iter.
// Upstream offers on R13 signals; downstream consumes R14 groups unless stalled.
interface bbox_sample_iter_if #(
    parameter int SIGFIG = 24,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
);
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S;
    logic [COLORS-1:0][SIGFIG-1:0]                 color_R13U;
    logic signed [1:0][1:0][SIGFIG-1:0]            box_R13S;
    logic                                          validTri_R13H;
    logic [3:0]                                    subSample_RnnnnU;
    logic                                          ready_R13H;
    logic                                          stall_R14H;
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S;
    logic [COLORS-1:0][SIGFIG-1:0]                 color_R14U;
    logic signed [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R14S;
    logic [SAMPS-1:0]                              validSamp_R14H;
    logic                                          last_R14H;

    modport master (
        output tri_R13S, color_R13U, box_R13S, validTri_R13H,
        output subSample_RnnnnU, stall_R14H,
        input  ready_R13H, tri_R14S, color_R14U, sample_R14S,
        input  validSamp_R14H, last_R14H
    );

    modport slave (
        input  tri_R13S, color_R13U, box_R13S, validTri_R13H,
        input  subSample_RnnnnU, stall_R14H,
        output ready_R13H, tri_R14S, color_R14U, sample_R14S,
        output validSamp_R14H, last_R14H
    );
endinterface

// File: rtl/bbox_sample_iter.sv
// Walks a triangle's bounding box on the sample grid, SAMPS samples per cycle,
// row by row from the snapped lower-left corner, with stall and back-to-back support.
module bbox_sample_iter #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
) (
    input logic clk,
    input logic rst,
    bbox_sample_iter_if.slave bus
);
    localparam int W = SIGFIG + 1;

    typedef enum logic {
        WAIT_STATE = 1'b0,
        TEST_STATE = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic signed [W-1:0] cur_x, cur_y, ll_x, ur_x, ur_y, step;
    logic signed [W-1:0] in_step, in_ll_x, in_ll_y, in_ur_x, in_ur_y;
    logic signed [W-1:0] adv_x, nxt_y;
    logic signed [W-1:0] xs [SAMPS];
    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
    logic [COLORS-1:0][SIGFIG-1:0] color_q;
    logic in_empty, wrap, last, accept;

    always_comb begin
        case (bus.subSample_RnnnnU)
            4'b0100: in_step = W'(1 << (RADIX - 1));
            4'b0010: in_step = W'(1 << (RADIX - 2));
            4'b0001: in_step = W'(1 << (RADIX - 3));
            default: in_step = W'(1 << RADIX);
        endcase
    end

    // Clearing the low bits of a two's-complement value rounds toward -inf.
    assign in_ll_x  = W'($signed(bus.box_R13S[0][0])) & ~(in_step - W'(1));
    assign in_ll_y  = W'($signed(bus.box_R13S[0][1])) & ~(in_step - W'(1));
    assign in_ur_x  = W'($signed(bus.box_R13S[1][0]));
    assign in_ur_y  = W'($signed(bus.box_R13S[1][1]));
    assign in_empty = (in_ur_x < in_ll_x) || (in_ur_y < in_ll_y);

    assign adv_x  = cur_x + W'(SAMPS) * step;
    assign nxt_y  = cur_y + step;
    assign wrap   = adv_x > ur_x;
    assign last   = (state == TEST_STATE) && wrap && (nxt_y > ur_y);
    assign accept = bus.validTri_R13H && bus.ready_R13H;

    assign bus.ready_R13H = (state == WAIT_STATE) ||
                            (last && !bus.stall_R14H);
    assign bus.last_R14H  = last;
    assign bus.tri_R14S   = tri_q;
    assign bus.color_R14U = color_q;

    always_comb begin
        for (int k = 0; k < SAMPS; k++) begin
            xs[k] = cur_x + W'(k) * step;
            bus.sample_R14S[0][k]  = xs[k][SIGFIG-1:0];
            bus.sample_R14S[1][k]  = cur_y[SIGFIG-1:0];
            bus.validSamp_R14H[k]  = (state == TEST_STATE) && (xs[k] <= ur_x);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= WAIT_STATE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_STATE: begin
                if (accept && !in_empty) state_nxt = TEST_STATE;
            end
            TEST_STATE: begin
                if (last && !bus.stall_R14H)
                    state_nxt = (accept && !in_empty) ? TEST_STATE : WAIT_STATE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_x   <= '0;
            cur_y   <= '0;
            ll_x    <= '0;
            ur_x    <= '0;
            ur_y    <= '0;
            step    <= '0;
            tri_q   <= '0;
            color_q <= '0;
        end else if (accept) begin
            cur_x   <= in_ll_x;
            cur_y   <= in_ll_y;
            ll_x    <= in_ll_x;
            ur_x    <= in_ur_x;
            ur_y    <= in_ur_y;
            step    <= in_step;
            tri_q   <= bus.tri_R13S;
            color_q <= bus.color_R13U;
        end else if (state == TEST_STATE && !bus.stall_R14H && !last) begin
            if (wrap) begin
                cur_x <= ll_x;
                cur_y <= nxt_y;
            end else begin
                cur_x <= adv_x;
            end
        end
    end
endmodule

// File: tb/tb_bbox_sample_iter.sv
// Bench for bbox_sample_iter: directed vector table, hand sequences, and random
// boxes checked against a row/column enumeration model of the sample grid.
module tb_bbox_sample_iter;
    localparam int SIGFIG = 24;
    localparam int SAMPS  = 4;
    localparam longint MSK = 64'hFFFFFF;

    typedef struct {
        longint     x [SAMPS];
        longint     y;
        logic [3:0] v;
        logic       last;
    } grp_t;

    typedef struct {
        logic [3:0] mode;
        longint     llx, lly, urx, ury;
        int         ng;
        longint     x0;
        logic [3:0] vlast;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    grp_t exp_q [$];
    vec_t vecs [7];
    logic signed [2:0][2:0][SIGFIG-1:0] exp_tri;
    logic [2:0][SIGFIG-1:0] exp_color;

    bbox_sample_iter_if #(.SIGFIG(SIGFIG), .SAMPS(SAMPS)) bus ();

    bbox_sample_iter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic chk_wide(input string nm, input logic [255:0] act,
                            input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic longint step_of(input logic [3:0] mode);
        case (mode)
            4'b1000: return 1024;
            4'b0100: return 512;
            4'b0010: return 256;
            4'b0001: return 128;
            default: return 1024;
        endcase
    endfunction

    // Enumerate rows bottom-up and groups left-to-right over the grid.
    function automatic void build(input logic [3:0] mode, input longint llx,
                                  input longint lly, input longint urx,
                                  input longint ury);
        longint st, sx, sy;
        grp_t g;
        exp_q.delete();
        st = step_of(mode);
        sx = llx - (((llx % st) + st) % st);
        sy = lly - (((lly % st) + st) % st);
        for (longint y = sy; y <= ury; y += st) begin
            for (longint x = sx; x <= urx; x += SAMPS * st) begin
                for (int k = 0; k < SAMPS; k++) begin
                    g.x[k] = x + k * st;
                    g.v[k] = (g.x[k] <= urx);
                end
                g.y = y;
                g.last = (x + SAMPS * st > urx) && (y + st > ury);
                exp_q.push_back(g);
            end
        end
    endfunction

    task automatic drive_tri(input logic [3:0] mode, input longint llx,
                             input longint lly, input longint urx,
                             input longint ury);
        bus.subSample_RnnnnU = mode;
        bus.box_R13S[0][0] = llx[SIGFIG-1:0];
        bus.box_R13S[0][1] = lly[SIGFIG-1:0];
        bus.box_R13S[1][0] = urx[SIGFIG-1:0];
        bus.box_R13S[1][1] = ury[SIGFIG-1:0];
        for (int a = 0; a < 3; a++) begin
            for (int b = 0; b < 3; b++) exp_tri[a][b] = SIGFIG'($urandom);
            exp_color[a] = SIGFIG'($urandom);
        end
        bus.tri_R13S = exp_tri;
        bus.color_R13U = exp_color;
    endtask

    task automatic check_group(input grp_t g, input string nm);
        for (int k = 0; k < SAMPS; k++)
            chk($sformatf("%s.x%0d", nm, k), bus.sample_R14S[0][k], g.x[k] & MSK);
        chk({nm, ".y"}, bus.sample_R14S[1][0], g.y & MSK);
        chk({nm, ".valid"}, bus.validSamp_R14H, g.v);
        chk({nm, ".last"}, bus.last_R14H, g.last);
        chk_wide({nm, ".tri"}, bus.tri_R14S, exp_tri);
        chk_wide({nm, ".color"}, bus.color_R14U, exp_color);
    endtask

    task automatic run_tri(input logic [3:0] mode, input longint llx,
                           input longint lly, input longint urx,
                           input longint ury, input int stall_pct,
                           input int first_stall, input string nm,
                           output int obs_n, output longint obs_x0,
                           output logic [3:0] obs_vlast);
        int i, cyc;
        bit done, st;
        build(mode, llx, lly, urx, ury);
        obs_n = 0;
        obs_x0 = -1;
        obs_vlast = '0;
        @(negedge clk);
        drive_tri(mode, llx, lly, urx, ury);
        bus.validTri_R13H = 1'b1;
        bus.stall_R14H = 1'b0;
        #1 chk({nm, ".ready_in"}, bus.ready_R13H, 1);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        if (exp_q.size() == 0) begin
            repeat (2) begin
                #1 chk({nm, ".empty_valid"}, bus.validSamp_R14H, 0);
                chk({nm, ".empty_ready"}, bus.ready_R13H, 1);
                @(negedge clk);
            end
            return;
        end
        i = 0;
        cyc = 0;
        done = 0;
        while (!done && cyc < 1000) begin
            st = (cyc < first_stall) || ($urandom_range(0, 99) < stall_pct);
            bus.stall_R14H = st;
            #1;
            if (i < exp_q.size()) begin
                check_group(exp_q[i], $sformatf("%s.g%0d", nm, i));
                chk({nm, ".ready"}, bus.ready_R13H, exp_q[i].last && !st);
            end
            if (!st) begin
                if (obs_n == 0) obs_x0 = longint'($signed(bus.sample_R14S[0][0]));
                obs_vlast = bus.validSamp_R14H;
                obs_n++;
                i++;
                if (bus.last_R14H) done = 1;
            end
            @(negedge clk);
            cyc++;
        end
        bus.stall_R14H = 1'b0;
        chk({nm, ".groups"}, obs_n, exp_q.size());
        #1 chk({nm, ".idle_valid"}, bus.validSamp_R14H, 0);
        chk({nm, ".idle_ready"}, bus.ready_R13H, 1);
    endtask

    initial begin
        int n;
        longint x0, llx, lly;
        logic [3:0] vl, md;
        vecs[0] = '{4'b1000, 0, 0, 3072, 1024, 2, 0, 4'b1111};
        vecs[1] = '{4'b1000, 0, 0, 1024, 0, 1, 0, 4'b0011};
        vecs[2] = '{4'b0100, 700, 0, 2048, 0, 1, 512, 4'b1111};
        vecs[3] = '{4'b1000, 2048, 0, 1024, 0, 0, 0, 4'b0000};
        vecs[4] = '{4'b0001, -300, -5, -1, 0, 2, -384, 4'b0111};
        vecs[5] = '{4'b0110, 0, 0, 5000, 0, 2, 0, 4'b0001};
        vecs[6] = '{4'b1000, 8387584, 0, 8388607, 0, 1, 8387584, 4'b0001};

        bus.validTri_R13H = 1'b0;
        bus.stall_R14H = 1'b0;
        bus.subSample_RnnnnU = 4'b1000;
        bus.tri_R13S = '0;
        bus.color_R13U = '0;
        bus.box_R13S = '0;
        exp_tri = '0;
        exp_color = '0;

        repeat (2) @(negedge clk);
        chk("rst.valid", bus.validSamp_R14H, 0);
        chk("rst.last", bus.last_R14H, 0);
        chk("rst.ready", bus.ready_R13H, 1);
        chk_wide("rst.sample", bus.sample_R14S, '0);
        chk_wide("rst.tri", bus.tri_R14S, '0);
        chk_wide("rst.color", bus.color_R14U, '0);
        rst = 1'b0;

        foreach (vecs[v]) begin
            run_tri(vecs[v].mode, vecs[v].llx, vecs[v].lly, vecs[v].urx,
                    vecs[v].ury, 0, 0, $sformatf("vec%0d", v), n, x0, vl);
            chk($sformatf("vec%0d.ngroups", v), n, vecs[v].ng);
            if (vecs[v].ng > 0) begin
                chk($sformatf("vec%0d.x0", v), x0, vecs[v].x0);
                chk($sformatf("vec%0d.vlast", v), vl, vecs[v].vlast);
            end
        end

        // Three stall cycles on the first group must freeze it in place.
        run_tri(4'b1000, 0, 0, 3072, 1024, 0, 3, "stall", n, x0, vl);
        chk("stall.ngroups", n, 2);

        // Back-to-back: second triangle accepted as the last group leaves.
        build(4'b1000, 0, 0, 1024, 0);
        @(negedge clk);
        drive_tri(4'b1000, 0, 0, 1024, 0);
        bus.validTri_R13H = 1'b1;
        @(negedge clk);
        #1 check_group(exp_q[0], "b2b.a");
        chk("b2b.ready", bus.ready_R13H, 1);
        build(4'b1000, 0, 0, 3072, 1024);
        drive_tri(4'b1000, 0, 0, 3072, 1024);
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        #1 check_group(exp_q[0], "b2b.b0");
        @(negedge clk);
        #1 check_group(exp_q[1], "b2b.b1");
        @(negedge clk);
        #1 chk("b2b.idle", bus.validSamp_R14H, 0);

        // Reset while the first group is on the outputs.
        build(4'b1000, 0, 0, 3072, 1024);
        @(negedge clk);
        drive_tri(4'b1000, 0, 0, 3072, 1024);
        bus.validTri_R13H = 1'b1;
        @(negedge clk);
        bus.validTri_R13H = 1'b0;
        #1 check_group(exp_q[0], "rmid.g0");
        #2 rst = 1'b1;
        #1 chk("rmid.valid", bus.validSamp_R14H, 0);
        chk("rmid.ready", bus.ready_R13H, 1);
        chk("rmid.last", bus.last_R14H, 0);
        chk_wide("rmid.tri", bus.tri_R14S, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            #1 chk("rmid.after", bus.validSamp_R14H, 0);
            @(negedge clk);
        end

        for (int r = 0; r < 40; r++) begin
            n = int'($urandom_range(0, 5));
            md = (n < 4) ? 4'(1 << n) : 4'($urandom_range(0, 15));
            llx = longint'($urandom_range(0, 6000)) - 3000;
            lly = longint'($urandom_range(0, 4000)) - 2000;
            run_tri(md, llx, lly,
                    llx + longint'($urandom_range(0, 3500)) - 500,
                    lly + longint'($urandom_range(0, 1700)) - 200,
                    25, 0, $sformatf("rnd%0d", r), n, x0, vl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bbox_sample_iter.md
BBOX_SAMPLE_ITER -- requirements
Module: bbox_sample_iter

Interface
REQ-001 SHALL have parameters:
- SIGFIG, 24, bits in position/color.
- RADIX, 10, fraction bits.
- VERTS, 3, vertices per triangle.
- AXIS, 3, axes per vertex.
- COLORS, 3, color channels.
- SAMPS, 4, samples emitted per cycle.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock; all state on posedge clk.
- rst  in  1  reset, asynchronous, active-high.
- tri_R13S  in  SIGFIG signed [VERTS][AXIS]  triangle vertices.
- color_R13U  in  SIGFIG [COLORS]  triangle color.
- box_R13S  in  SIGFIG signed [2][2]  bounding box; [0]=lower-left, [1]=upper-right; [.][0]=x, [.][1]=y.
- validTri_R13H  in  1  upstream offers a triangle.
- subSample_RnnnnU  in  4  one-hot sample-rate mode.
- ready_R13H  out  1  block accepts the offered triangle this cycle.
- stall_R14H  in  1  downstream (sample test) cannot consume this cycle.
- tri_R14S  out  SIGFIG signed [VERTS][AXIS]  registered triangle.
- color_R14U  out  SIGFIG [COLORS]  registered color.
- sample_R14S  out  SIGFIG signed [2][SAMPS]  sample locations; [0]=x, [1]=y.
- validSamp_R14H  out  1 [SAMPS]  per-sample valid.
- last_R14H  out  1  current group is the final one for the triangle.

Function
REQ-003 SHALL implement a two-state FSM: WAIT_STATE (idle) and TEST_STATE (iterating).
REQ-004 SHALL accept a triangle when validTri_R13H && ready_R13H. On accept it SHALL capture tri, color, box and subSample, which stay fixed for that triangle.
REQ-005 SHALL drive ready_R13H = (WAIT_STATE) || (TEST_STATE && last_R14H && !stall_R14H), so back-to-back triangles incur no bubble.
REQ-006 SHALL derive step from subSample_RnnnnU:
- 1000: 1<<RADIX
- 0100: 1<<(RADIX-1)
- 0010: 1<<(RADIX-2)
- 0001: 1<<(RADIX-3)
- Any non-one-hot value SHALL be treated as 1000.
REQ-007 SHALL snap the captured lower-left x and y down to the step grid by clearing the bits below log2(step). Upper-right SHALL be used unmodified.
REQ-008 Sample k of a group SHALL be at x = cur_x + k*step, y = cur_y. validSamp[k] = 1 iff in TEST_STATE and x_k <= ur_x (signed compare).
REQ-009 First group SHALL appear on outputs the cycle after accept (latency 1), with cur = snapped lower-left.
REQ-010 Each cycle in TEST_STATE with stall_R14H=0, the block SHALL advance:
- if cur_x + SAMPS*step <= ur_x: cur_x += SAMPS*step.
- else: cur_x = snapped ll_x, cur_y += step.
REQ-011 last_R14H SHALL be 1 when the row wraps and cur_y + step > ur_y.
REQ-012 When a last group is consumed (!stall), the FSM SHALL:
- go to WAIT_STATE and clear all validSamp, or
- if a new triangle is accepted that cycle, load it and stay in TEST_STATE.
REQ-013 With stall_R14H=1, all R14 outputs and internal state SHALL hold unchanged.
REQ-014 An empty box (ur_x < ll_x or ur_y < ll_y after snapping) SHALL be accepted but emit no valid samples. The FSM stays in WAIT_STATE and ready_R13H stays 1.
REQ-015 Coordinate adds SHALL be SIGFIG+1 bits wide internally so that an increment past a box near the positive limit compares correctly with no wrap-around.
REQ-016 tri_R14S and color_R14U SHALL equal the captured triangle for every group of that triangle.

Reset
REQ-017 While rst=1, the block SHALL be in WAIT_STATE with all outputs zero: validSamp_R14H all 0, last_R14H 0, sample_R14S 0, tri_R14S 0, color_R14U 0. ready_R13H SHALL be 1.
REQ-018 rst asserted mid-triangle SHALL abandon it immediately. No valid sample SHALL appear until a new triangle is accepted after rst deasserts.

Verification
REQ-019 Full-pixel multi-row: SAMPS=4, mode 1000, box ll=(0,0), ur=(3072,1024), no stall. Required response:
- cycle+1: x={0,1024,2048,3072}, y=0, valid=1111, last=0.
- cycle+2: y=1024, valid=1111, last=1.
- then WAIT_STATE.
REQ-020 Partial group: box ll=(0,0), ur=(1024,0). Required response: one group, x={0,1024,2048,3072}, valid=1100, last=1.
REQ-021 Subsample 4x: mode 0100, box ll=(700,0), ur=(2048,0). Required response:
- ll_x snapped to 512.
- group1 x={512,1024,1536,2048}, valid=1111, last=1.
REQ-022 Stall: assert stall_R14H for 3 cycles during group 1 of REQ-019. Required response: outputs hold those 3 cycles; sequence then resumes identically; ready_R13H stays 0 until last is consumed.
REQ-023 Back-to-back plus empty box:
- A second triangle is offered while the last group of REQ-020 is consumed. It SHALL be accepted that cycle, and its first group SHALL follow with no idle cycle.
- An empty box (ll=(2048,0), ur=(1024,0)) SHALL produce no valid samples.
REQ-024 Reset mid-op: assert rst during group 1 of REQ-019. Required response: validSamp all 0 and ready_R13H=1 asynchronously; no further samples after rst release.
